// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between load completions and parked/direct ALU results.
module wb_port_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  output logic        stall_o,
  input  logic        ld_issue_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [4:0]  ld_rd_i,
  input  logic [1:0]  ld_offset_i,
  output logic        ld_ready_o,
  output logic        ld_pending_o,
  output logic [4:0]  ld_pending_rd_o,
  output logic        ld_err_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [2:0] f3_q, f3_d;
  logic [4:0] rd_q, rd_d;
  logic [1:0] off_q, off_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [36:0] fifo_q [FIFO_DEPTH];
  logic we_q, we_d, err_q, err_d;
  logic [4:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d, ld_data;
  logic [7:0] byte_s;
  logic [15:0] half_s;
  logic [36:0] head;
  logic illegal, ld_done, alu_acc, direct, push, pop;
  always_comb begin
    illegal = ld_funct3_i == 3'b011 || ld_funct3_i[2:1] == 2'b11 ||
              (ld_funct3_i[1:0] == 2'b01 && ld_offset_i[0]) ||
              (ld_funct3_i == 3'b010 && ld_offset_i != 2'd0);
    byte_s  = mem_rdata_i[8*off_q +: 8];
    half_s  = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    ld_data = f3_q == 3'b000 ? {{24{byte_s[7]}}, byte_s} :
              f3_q == 3'b001 ? {{16{half_s[15]}}, half_s} :
              f3_q == 3'b100 ? {24'd0, byte_s} :
              f3_q == 3'b101 ? {16'd0, half_s} : mem_rdata_i;
    stall_o = cnt_q == FULL;
    ld_done = state_q == WAIT && mem_rvalid_i;
    alu_acc = alu_valid_i && !stall_o && alu_rd_i != 5'd0;
    pop     = !ld_done && cnt_q != '0;
    direct  = !ld_done && cnt_q == '0 && alu_acc;
    push    = alu_acc && !direct;
    head    = fifo_q[rd_ptr_q];
    // a load to x0 still wins the port cycle but writes nothing
    we_d    = (ld_done && rd_q != 5'd0) || pop || direct;
    waddr_d = !we_d ? waddr_q : ld_done ? rd_q : pop ? head[36:32] : alu_rd_i;
    wdata_d = !we_d ? wdata_q : ld_done ? ld_data : pop ? head[31:0] : alu_data_i;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = push && !pop ? cnt_q + 1'b1 : !push && pop ? cnt_q - 1'b1 : cnt_q;
    err_d    = state_q == IDLE && ld_issue_i && illegal;
    state_d  = state_q == IDLE && ld_issue_i && !illegal ? WAIT : ld_done ? IDLE : state_q;
    f3_d     = state_q == IDLE && ld_issue_i ? ld_funct3_i : f3_q;
    rd_d     = state_q == IDLE && ld_issue_i ? ld_rd_i : rd_q;
    off_d    = state_q == IDLE && ld_issue_i ? ld_offset_i : off_q;
    ld_ready_o      = state_q == IDLE;
    ld_pending_o    = state_q == WAIT;
    ld_pending_rd_o = state_q == WAIT ? rd_q : 5'd0;
    ld_err_o    = err_q;
    reg_we_o    = we_q;
    reg_waddr_o = waddr_q;
    reg_wdata_o = wdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      rd_q     <= '0;
      off_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      off_q    <= off_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_q[wr_ptr_q] <= {alu_rd_i, alu_data_i};
  end
endmodule
